// File: rtl/cache_tag_maint_ctrl_pkg.sv
// Shared state encoding and geometry helpers for the tag-store maintenance sequencer.
// The width helpers mirror the cache geometry rules used across the cache slice.
package cache_tag_maint_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } maint_state_e;

    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lines_per_bank(input int cache_size, input int line_size,
                                          input int num_banks, input int num_ways);
        return cache_size / (line_size * num_banks * num_ways);
    endfunction

    // Bank-local line address: byte address minus line offset and bank select bits.
    function automatic int line_addr_width(input int line_size, input int num_banks);
        return MEM_ADDR_WIDTH - $clog2(line_size) - $clog2(num_banks);
    endfunction

endpackage

// File: rtl/cache_tag_maint_ctrl_line_walker.sv
// Set/way walker shared by the init sweep and the flush walk.
// In line_only mode the way counter is frozen and every step advances the set.
module cache_line_walker
    import cache_tag_maint_ctrl_pkg::*;
#(
    parameter  int LINES     = 32,
    parameter  int WAYS      = 1,
    localparam int LINE_BITS = sel_bits(LINES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 step,
    input  logic                 line_only,
    output logic [LINE_BITS-1:0] line,
    output logic [WAYS-1:0]      way_onehot,
    output logic                 last
);

    localparam logic [LINE_BITS-1:0] LINE_MAX = LINE_BITS'(LINES - 1);

    logic [LINE_BITS-1:0] line_cnt;
    logic                 way_last;
    logic                 line_adv;

    generate
        if (WAYS > 1) begin : g_way
            localparam int WAY_BITS = $clog2(WAYS);
            localparam logic [WAY_BITS-1:0] WAY_MAX = WAY_BITS'(WAYS - 1);

            logic [WAY_BITS-1:0] way_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    way_cnt <= '0;
                end else if (clear) begin
                    way_cnt <= '0;
                end else if (step && !line_only) begin
                    way_cnt <= (way_cnt == WAY_MAX) ? '0 : way_cnt + WAY_BITS'(1);
                end
            end

            assign way_last   = (way_cnt == WAY_MAX);
            assign way_onehot = WAYS'(1) << way_cnt;
        end else begin : g_no_way
            assign way_last   = 1'b1;
            assign way_onehot = 1'b1;
        end
    endgenerate

    assign line_adv = step && (line_only || way_last);

    // Wrap on the last real set so non-power-of-two set counts stay in range.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt <= '0;
        end else if (clear) begin
            line_cnt <= '0;
        end else if (line_adv) begin
            line_cnt <= (line_cnt == LINE_MAX) ? '0 : line_cnt + LINE_BITS'(1);
        end
    end

    assign line = line_cnt;
    assign last = (line_cnt == LINE_MAX) && (line_only || way_last);

endmodule

// File: rtl/cache_tag_maint_ctrl.sv
// Per-bank tag-store maintenance sequencer: post-reset init sweep, then on request
// drain the pipeline and invalidate every (set, way), writing back dirty victims.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_INIT  | sweep every set with tag_init after reset
//  ST_IDLE  | accept flush requests, core runs freely
//  ST_DRAIN | core blocked, waiting for the bank pipeline to empty
//  ST_FLUSH | invalidate one (set, way) per cycle, stall on dirty victims
//  ST_DONE  | present flush_rsp until accepted
module cache_tag_maint_ctrl
    import cache_tag_maint_ctrl_pkg::*;
#(
    parameter  string INSTANCE_ID = "",
    parameter  int    BANK_ID     = 0,
    parameter  int    CACHE_SIZE  = 1024,
    parameter  int    LINE_SIZE   = 16,
    parameter  int    NUM_BANKS   = 1,
    parameter  int    NUM_WAYS    = 1,
    parameter  int    WORD_SIZE   = 1,
    parameter  int    WRITEBACK   = 0,
    localparam int    CS_LINES_PER_BANK  = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
    localparam int    CS_LINE_SEL_BITS   = sel_bits(CS_LINES_PER_BANK),
    localparam int    CS_LINE_ADDR_WIDTH = line_addr_width(LINE_SIZE, NUM_BANKS),
    localparam int    CS_TAG_SEL_BITS    = CS_LINE_ADDR_WIDTH - CS_LINE_SEL_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush_req_valid,
    output logic                          flush_req_ready,
    output logic                          flush_rsp_valid,
    input  logic                          flush_rsp_ready,
    input  logic                          pipe_idle,
    output logic                          core_block,
    output logic                          busy,
    output logic                          tag_init,
    output logic                          tag_flush_line,
    output logic [NUM_WAYS-1:0]           tag_flush_way_sel,
    output logic [CS_LINE_SEL_BITS-1:0]   tag_line_sel,
    output logic                          tag_stall,
    input  logic                          tag_eviction,
    input  logic [CS_TAG_SEL_BITS-1:0]    tag_evicted_tag,
    output logic                          wb_req_valid,
    input  logic                          wb_req_ready,
    output logic [CS_LINE_ADDR_WIDTH-1:0] wb_req_addr,
    output logic [NUM_WAYS-1:0]           wb_req_way
);

    localparam bit WB_EN = (WRITEBACK != 0);

    maint_state_e state, state_next;

    logic                        walk_clear;
    logic                        walk_step;
    logic                        walk_line_only;
    logic                        walk_last;
    logic [CS_LINE_SEL_BITS-1:0] walk_line;
    logic [NUM_WAYS-1:0]         walk_way;
    logic                        dirty;

    cache_line_walker #(
        .LINES (CS_LINES_PER_BANK),
        .WAYS  (NUM_WAYS)
    ) u_walker (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (walk_clear),
        .step       (walk_step),
        .line_only  (walk_line_only),
        .line       (walk_line),
        .way_onehot (walk_way),
        .last       (walk_last)
    );

    assign dirty = WB_EN && tag_eviction;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        flush_req_ready = 1'b0;
        flush_rsp_valid = 1'b0;
        core_block      = 1'b1;
        busy            = 1'b1;
        tag_init        = 1'b0;
        tag_flush_line  = 1'b0;
        tag_stall       = 1'b0;
        wb_req_valid    = 1'b0;
        walk_clear      = 1'b0;
        walk_step       = 1'b0;
        walk_line_only  = 1'b0;
        case (state)
            ST_INIT: begin
                // Gated so the tag store sees no init pulse while reset is held.
                tag_init       = reset_n;
                walk_line_only = 1'b1;
                walk_step      = 1'b1;
                if (walk_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                flush_req_ready = 1'b1;
                core_block      = 1'b0;
                busy            = 1'b0;
                walk_clear      = 1'b1;
                if (flush_req_valid) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b0;
                if (pipe_idle) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                tag_flush_line = 1'b1;
                wb_req_valid   = dirty;
                tag_stall      = dirty && !wb_req_ready;
                walk_step      = !dirty || wb_req_ready;
                if (walk_step && walk_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy            = 1'b0;
                flush_rsp_valid = 1'b1;
                if (flush_rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign tag_line_sel      = walk_line;
    assign tag_flush_way_sel = tag_flush_line ? walk_way : '0;
    assign wb_req_way        = wb_req_valid ? walk_way : '0;
    assign wb_req_addr       = wb_req_valid ? {tag_evicted_tag, walk_line} : '0;

endmodule

// File: tb/tb_cache_tag_maint_ctrl.sv
// Scoreboard bench for cache_tag_maint_ctrl: 32 sets x 2 ways, writeback build.
module tb_cache_tag_maint_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush_req_valid;
    logic        flush_req_ready;
    logic        flush_rsp_valid;
    logic        flush_rsp_ready;
    logic        pipe_idle;
    logic        core_block;
    logic        busy;
    logic        tag_init;
    logic        tag_flush_line;
    logic [1:0]  tag_flush_way_sel;
    logic [4:0]  tag_line_sel;
    logic        tag_stall;
    logic        tag_eviction;
    logic [22:0] tag_evicted_tag;
    logic        wb_req_valid;
    logic        wb_req_ready;
    logic [27:0] wb_req_addr;
    logic [1:0]  wb_req_way;
    logic        dirty_en;

    int total = 0;
    int bad   = 0;
    int init_cycles  = 0;
    int stall_cycles = 0;

    logic [4:0]  init_q[$];
    logic [6:0]  flush_q[$];
    logic [29:0] wb_q[$];

    logic        wb_hold = 1'b0;
    logic [29:0] wb_prev = '0;

    always #5 clk = ~clk;

    // Tag-store model: set 5 way 1 holds a dirty line with tag 0x3A.
    assign tag_eviction    = dirty_en && tag_flush_line && (tag_line_sel == 5'd5) && (tag_flush_way_sel == 2'b10);
    assign tag_evicted_tag = 23'h3A;

    cache_tag_maint_ctrl #(
        .INSTANCE_ID ("tb_bank0"),
        .BANK_ID     (0),
        .CACHE_SIZE  (1024),
        .LINE_SIZE   (16),
        .NUM_BANKS   (1),
        .NUM_WAYS    (2),
        .WORD_SIZE   (1),
        .WRITEBACK   (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush_req_valid   (flush_req_valid),
        .flush_req_ready   (flush_req_ready),
        .flush_rsp_valid   (flush_rsp_valid),
        .flush_rsp_ready   (flush_rsp_ready),
        .pipe_idle         (pipe_idle),
        .core_block        (core_block),
        .busy              (busy),
        .tag_init          (tag_init),
        .tag_flush_line    (tag_flush_line),
        .tag_flush_way_sel (tag_flush_way_sel),
        .tag_line_sel      (tag_line_sel),
        .tag_stall         (tag_stall),
        .tag_eviction      (tag_eviction),
        .tag_evicted_tag   (tag_evicted_tag),
        .wb_req_valid      (wb_req_valid),
        .wb_req_ready      (wb_req_ready),
        .wb_req_addr       (wb_req_addr),
        .wb_req_way        (wb_req_way)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: inputs are driven just after the falling edge.
    task automatic tk();
        @(negedge clk);
        #1;
    endtask

    task automatic push_init();
        for (int l = 0; l < 32; l++) begin
            init_q.push_back(5'(l));
        end
    endtask

    task automatic push_flush();
        for (int l = 0; l < 32; l++) begin
            for (int w = 0; w < 2; w++) begin
                flush_q.push_back({5'(l), 2'(1 << w)});
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int rsp_seen);
        int k;
        k = 0;
        rsp_seen = 0;
        while (!flush_req_ready && k < budget) begin
            tk();
            k++;
            if (flush_rsp_valid) rsp_seen++;
        end
        chk("idle_reached", flush_req_ready, 1);
    endtask

    // Issue a flush from IDLE and run it to the response; n counts cycles after accept.
    task automatic run_flush(input int drain_cycles, output int n);
        int stall_seen;
        flush_req_valid = 1'b1;
        n = 0;
        stall_seen = 0;
        do begin
            tk();
            n++;
            if (n == 1) begin
                flush_req_valid = 1'b0;
                chk("acc_core_block", core_block, 1);
                chk("acc_req_ready", flush_req_ready, 0);
            end
            if (n <= drain_cycles) begin
                chk("drain_core_block", core_block, 1);
                chk("drain_no_flush", tag_flush_line, 0);
                if (n == drain_cycles) pipe_idle = 1'b1;
            end
            if (wb_req_valid && !wb_req_ready) begin
                stall_seen++;
                chk("wb_tag_stall", tag_stall, 1);
                if (stall_seen == 5) wb_req_ready = 1'b1;
            end else if (wb_req_ready) begin
                wb_req_ready = 1'b0;
            end
        end while (!flush_rsp_valid && n < 400);
        chk("rsp_reached", flush_rsp_valid, 1);
    endtask

    task automatic rsp_handshake();
        flush_rsp_ready = 1'b0;
        repeat (2) begin
            tk();
            chk("rsp_hold", flush_rsp_valid, 1);
        end
        flush_rsp_ready = 1'b1;
        tk();
        chk("rsp_released", flush_rsp_valid, 0);
        chk("rsp_back_idle", flush_req_ready, 1);
        flush_rsp_ready = 1'b0;
    endtask

    always begin
        @(negedge clk);
        #3;
        chk("init_flush_excl", tag_init & tag_flush_line, 0);
        if (tag_init) begin
            init_cycles++;
            chk("init_req_ready", flush_req_ready, 0);
            chk("init_busy", busy, 1);
            if (init_q.size() == 0) chk("init_q_underflow", init_q.size(), 1);
            else chk("init_line", tag_line_sel, init_q.pop_front());
        end
        if (tag_flush_line) begin
            chk("flush_busy", busy, 1);
            chk("flush_core_block", core_block, 1);
            if (!tag_stall) begin
                if (flush_q.size() == 0) chk("flush_q_underflow", flush_q.size(), 1);
                else chk("flush_entry", {tag_line_sel, tag_flush_way_sel}, flush_q.pop_front());
            end
        end
        if (tag_stall) stall_cycles++;
        if (wb_hold) begin
            chk("wb_hold_valid", wb_req_valid, 1);
            chk("wb_hold_payload", {wb_req_addr, wb_req_way}, wb_prev);
        end
        if (wb_req_valid && wb_req_ready) begin
            if (wb_q.size() == 0) chk("wb_q_underflow", wb_q.size(), 1);
            else chk("wb_req", {wb_req_addr, wb_req_way}, wb_q.pop_front());
        end
        wb_hold = wb_req_valid && !wb_req_ready;
        wb_prev = {wb_req_addr, wb_req_way};
    end

    initial begin
        int n;
        int k;
        int rsp_seen;

        reset_n         = 1'b0;
        flush_req_valid = 1'b0;
        flush_rsp_ready = 1'b0;
        pipe_idle       = 1'b1;
        wb_req_ready    = 1'b0;
        dirty_en        = 1'b0;
        repeat (3) tk();
        chk("rst_busy", busy, 1);
        chk("rst_core_block", core_block, 1);
        chk("rst_tag_init", tag_init, 0);
        chk("rst_req_ready", flush_req_ready, 0);
        chk("rst_rsp_valid", flush_rsp_valid, 0);
        chk("rst_flush_line", tag_flush_line, 0);
        chk("rst_wb_valid", wb_req_valid, 0);
        chk("rst_line_sel", tag_line_sel, 0);

        // Init sweep with a flush request already pending.
        push_init();
        init_cycles     = 0;
        flush_req_valid = 1'b1;
        reset_n         = 1'b1;
        wait_idle(100, rsp_seen);
        chk("init_cycles", init_cycles, 32);

        // Clean flush with the pipeline already idle.
        push_flush();
        run_flush(0, n);
        chk("clean_latency", n, 66);
        rsp_handshake();
        chk("clean_flush_q_empty", flush_q.size(), 0);

        // Ten-cycle drain, then a dirty victim held off for four cycles.
        pipe_idle    = 1'b0;
        dirty_en     = 1'b1;
        stall_cycles = 0;
        wb_q.push_back({28'h745, 2'b10});
        push_flush();
        run_flush(10, n);
        chk("wb_latency", n, 79);
        chk("wb_stall_cycles", stall_cycles, 4);
        flush_rsp_ready = 1'b1;
        tk();
        flush_rsp_ready = 1'b0;
        dirty_en        = 1'b0;
        chk("wb_flush_q_empty", flush_q.size(), 0);

        // Reset in the middle of a flush at set 17.
        push_flush();
        flush_req_valid = 1'b1;
        tk();
        flush_req_valid = 1'b0;
        k = 0;
        while (!(tag_flush_line && tag_line_sel == 5'd17) && k < 200) begin
            tk();
            k++;
        end
        chk("abort_reach_set17", tag_line_sel, 17);
        reset_n = 1'b0;
        flush_q.delete();
        tk();
        chk("abort_line_sel", tag_line_sel, 0);
        chk("abort_flush_line", tag_flush_line, 0);
        chk("abort_rsp", flush_rsp_valid, 0);
        chk("abort_busy", busy, 1);
        push_init();
        init_cycles = 0;
        reset_n     = 1'b1;
        wait_idle(100, rsp_seen);
        chk("abort_init_cycles", init_cycles, 32);
        chk("abort_no_rsp", rsp_seen, 0);

        tk();
        chk("end_init_q", init_q.size(), 0);
        chk("end_flush_q", flush_q.size(), 0);
        chk("end_wb_q", wb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
